// File: rtl/cpu_types.sv
// rtl/cpu_types.sv - shared CPU-side types for the data RAM controller
package cpu_types;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    WAIT,
    RESP
  } ram_ctrl_state_t;

  localparam int RAM_CTRL_MAX_WAIT = 15;

endpackage

// File: rtl/ram_write_buffer.sv
// rtl/ram_write_buffer.sv - one-entry posted-write buffer (address, data, byte enables, full flag)
module ram_write_buffer #(
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     clear,
  input  logic [ADDRESS_WIDTH-1:0] load_addr,
  input  logic [31:0]              load_data,
  input  logic [3:0]               load_be,
  output logic                     full,
  output logic [ADDRESS_WIDTH-1:0] addr,
  output logic [31:0]              data,
  output logic [3:0]               be
);

  // Capture a posted write; the controller clears the entry once its drain finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      addr <= '0;
      data <= '0;
      be   <= '0;
    end else if (load) begin
      full <= 1'b1;
      addr <= load_addr;
      data <= load_data;
      be   <= load_be;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/data_ram_controller.sv
// rtl/data_ram_controller.sv - CPU data port to SRAM controller; optional write buffer via DATA_RAM_CONTROLLER_WRITE_BUFFER_EN
module data_ram_controller
  import cpu_types::*;
#(
  parameter int ADDRESS_WIDTH = 12,
  parameter int WAIT_STATES   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req,
  input  logic                     we,
  input  logic [31:0]              address,
  input  logic [31:0]              write_data,
  input  logic [3:0]               byte_enable,
  output logic                     ready,
  output logic [31:0]              read_data,
  output logic                     fault,
  output logic                     sram_en,
  output logic                     sram_we,
  output logic [ADDRESS_WIDTH-1:0] sram_addr,
  output logic [31:0]              sram_wdata,
  output logic [3:0]               sram_be,
  input  logic [31:0]              sram_rdata
);

  // Out-of-range wait settings saturate at the counter's capacity.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > RAM_CTRL_MAX_WAIT) ?
                                     4'(RAM_CTRL_MAX_WAIT) : 4'(WAIT_STATES);

  ram_ctrl_state_t          state;
  logic [3:0]               wait_cnt;
  logic                     lat_we;
  logic                     ready_q;
  logic                     fault_q;
  logic                     in_range;
  logic [ADDRESS_WIDTH-1:0] word_addr;
  logic                     buf_full;
  logic                     buf_accept;
  logic [ADDRESS_WIDTH-1:0] buf_addr;
  logic [31:0]              buf_data;
  logic [3:0]               buf_be;
  logic                     unused_addr_lsbs;

  assign in_range         = (address[31:ADDRESS_WIDTH+2] == '0);
  assign word_addr        = address[ADDRESS_WIDTH+1:2];
  assign unused_addr_lsbs = ^address[1:0];

`ifdef DATA_RAM_CONTROLLER_WRITE_BUFFER_EN
  logic drain_done;

  // A write is posted only from IDLE with an empty buffer; it completes in the same cycle.
  assign buf_accept = rst_n && (state == IDLE) && req && we && in_range && !buf_full;
  assign drain_done = buf_full &&
                      (((state == CAPTURE) && (WAIT_LOAD == 4'd0)) ||
                       ((state == WAIT) && (wait_cnt <= 4'd1)));

  ram_write_buffer #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_write_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (buf_accept),
    .clear     (drain_done),
    .load_addr (word_addr),
    .load_data (write_data),
    .load_be   (byte_enable),
    .full      (buf_full),
    .addr      (buf_addr),
    .data      (buf_data),
    .be        (buf_be)
  );

  assign ready = ready_q | buf_accept;
  assign fault = fault_q & ~buf_accept;
`else
  assign buf_full   = 1'b0;
  assign buf_accept = 1'b0;
  assign buf_addr   = '0;
  assign buf_data   = '0;
  assign buf_be     = '0;
  assign ready      = ready_q;
  assign fault      = fault_q;
`endif

  // Access sequencer: SRAM strobes and the response are registered on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      lat_we     <= 1'b0;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
      read_data  <= '0;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_be    <= '0;
    end else begin
      ready_q    <= 1'b0;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_be    <= '0;
      case (state)
        IDLE: begin
          if (buf_full) begin
            // Drain the posted write; any waiting request stays stalled here.
            state      <= ISSUE;
            lat_we     <= 1'b1;
            sram_en    <= 1'b1;
            sram_we    <= 1'b1;
            sram_addr  <= buf_addr;
            sram_wdata <= buf_data;
            sram_be    <= buf_be;
          end else if (req && !in_range) begin
            state     <= RESP;
            ready_q   <= 1'b1;
            fault_q   <= 1'b1;
            read_data <= '0;
          end else if (req && !buf_accept) begin
            // The SRAM-side registers double as the request latch for ISSUE.
            state      <= ISSUE;
            lat_we     <= we;
            sram_en    <= 1'b1;
            sram_we    <= we;
            sram_addr  <= word_addr;
            sram_wdata <= write_data;
            sram_be    <= byte_enable;
          end
        end
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          if (!lat_we) begin
            read_data <= sram_rdata;
          end
          wait_cnt <= WAIT_LOAD;
          if (WAIT_LOAD != 4'd0) begin
            state <= WAIT;
          end else if (buf_full) begin
            state <= IDLE;
          end else begin
            state   <= RESP;
            ready_q <= 1'b1;
            fault_q <= 1'b0;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) begin
            if (buf_full) begin
              state <= IDLE;
            end else begin
              state   <= RESP;
              ready_q <= 1'b1;
              fault_q <= 1'b0;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_controller.sv
// tb/tb_data_ram_controller.sv - directed table-driven bench for data_ram_controller
module tb_data_ram_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic        we;
  logic [31:0] address, write_data;
  logic [3:0]  byte_enable;

  logic        ready0, fault0, sram_en0, sram_we0;
  logic [31:0] read_data0, sram_wdata0, sram_rdata0;
  logic [11:0] sram_addr0;
  logic [3:0]  sram_be0;

  logic        ready1, fault1, sram_en1, sram_we1;
  logic [31:0] read_data1, sram_wdata1, sram_rdata1;
  logic [11:0] sram_addr1;
  logic [3:0]  sram_be1;

  logic [31:0] mem0 [0:4095];
  logic [31:0] mem1 [0:4095];

  int tests = 0;
  int fails = 0;
  int cyc_count = 0;
  logic sel = 1'b0;

  logic        m_ready, m_fault, m_en;
  logic [31:0] m_rdata;
  assign m_ready = sel ? ready1 : ready0;
  assign m_fault = sel ? fault1 : fault0;
  assign m_en    = sel ? sram_en1 : sram_en0;
  assign m_rdata = sel ? read_data1 : read_data0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_count <= cyc_count + 1;

  data_ram_controller #(.ADDRESS_WIDTH(12), .WAIT_STATES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we), .address(address),
    .write_data(write_data), .byte_enable(byte_enable), .ready(ready0),
    .read_data(read_data0), .fault(fault0), .sram_en(sram_en0), .sram_we(sram_we0),
    .sram_addr(sram_addr0), .sram_wdata(sram_wdata0), .sram_be(sram_be0),
    .sram_rdata(sram_rdata0)
  );

  data_ram_controller #(.ADDRESS_WIDTH(12), .WAIT_STATES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .we(we), .address(address),
    .write_data(write_data), .byte_enable(byte_enable), .ready(ready1),
    .read_data(read_data1), .fault(fault1), .sram_en(sram_en1), .sram_we(sram_we1),
    .sram_addr(sram_addr1), .sram_wdata(sram_wdata1), .sram_be(sram_be1),
    .sram_rdata(sram_rdata1)
  );

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem0[i] <= 32'h5A000000 | i;
      mem1[i] <= 32'hA5000000 | i;
    end
  end

  always @(posedge clk) begin
    if (sram_en0) begin
      if (sram_we0) begin
        for (int k = 0; k < 4; k++)
          if (sram_be0[k]) mem0[sram_addr0][8*k +: 8] <= sram_wdata0[8*k +: 8];
      end else begin
        sram_rdata0 <= mem0[sram_addr0];
      end
    end
  end

  always @(posedge clk) begin
    if (sram_en1) begin
      if (sram_we1) begin
        for (int k = 0; k < 4; k++)
          if (sram_be1[k]) mem1[sram_addr1][8*k +: 8] <= sram_wdata1[8*k +: 8];
      end else begin
        sram_rdata1 <= mem1[sram_addr1];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic check_idle0(input string tag);
    check({tag, " ready"}, 32'(ready0), 32'd0);
    check({tag, " read_data"}, read_data0, 32'd0);
    check({tag, " fault"}, 32'(fault0), 32'd0);
    check({tag, " sram_en"}, 32'(sram_en0), 32'd0);
    check({tag, " sram_we"}, 32'(sram_we0), 32'd0);
    check({tag, " sram_addr"}, 32'(sram_addr0), 32'd0);
    check({tag, " sram_wdata"}, sram_wdata0, 32'd0);
    check({tag, " sram_be"}, 32'(sram_be0), 32'd0);
  endtask

  // One core access: drive in cycle 0, count cycles until ready, release after the ready edge.
  task automatic access(input logic d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b,
                        output int lat, output logic [31:0] rd, output logic flt,
                        output logic en_seen, output int start);
    @(negedge clk);
    sel = d; we = w; address = a; write_data = wd; byte_enable = b;
    if (d) req1 = 1'b1; else req0 = 1'b1;
    start = cyc_count;
    #1;
    lat = 0;
    en_seen = 1'b0;
    while (!m_ready && lat < 40) begin
      @(negedge clk);
      lat++;
      if (m_en) en_seen = 1'b1;
    end
    rd  = m_rdata;
    flt = m_fault;
    @(posedge clk);
    #1;
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_f;
    int          exp_lat;
  } vec_t;

  vec_t vecs [14];

  int          lat, start_a, start_b;
  logic [31:0] rd;
  logic        flt, en_seen;

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        1'b0, 4};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 1'b0, 4};
    vecs[2]  = '{1'b1, 32'h0000_0020, 32'h11223344, 4'hF, 1'b0, 32'h0,        1'b0, 4};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'h000000AA, 4'h1, 1'b0, 32'h0,        1'b0, 4};
    vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,        4'h0, 1'b1, 32'h112233AA, 1'b0, 4};
    vecs[5]  = '{1'b0, 32'h0001_0000, 32'h0,        4'h0, 1'b1, 32'h0,        1'b1, 1};
    vecs[6]  = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 1'b0, 4};
    vecs[7]  = '{1'b1, 32'h0000_3FFC, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0,        1'b0, 4};
    vecs[8]  = '{1'b0, 32'h0000_3FFF, 32'h0,        4'h0, 1'b1, 32'hCAFEF00D, 1'b0, 4};
    vecs[9]  = '{1'b0, 32'h0000_4000, 32'h0,        4'h0, 1'b1, 32'h0,        1'b1, 1};
    vecs[10] = '{1'b1, 32'h0000_0012, 32'h0000AB00, 4'h2, 1'b0, 32'h0,        1'b0, 4};
    vecs[11] = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, 1'b1, 32'hDEADABEF, 1'b0, 4};
    vecs[12] = '{1'b1, 32'h8000_0000, 32'h12345678, 4'hF, 1'b1, 32'h0,        1'b1, 1};
    vecs[13] = '{1'b0, 32'h0000_0040, 32'h0,        4'h0, 1'b1, 32'h5A000010, 1'b0, 4};

    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we = 1'b0;
    address = '0; write_data = '0; byte_enable = '0;
    repeat (3) @(negedge clk);
    #1;
    check_idle0("reset");
    @(negedge clk);
    rst_n = 1'b1;

`ifndef DATA_RAM_CONTROLLER_WRITE_BUFFER_EN
    for (int i = 0; i < 14; i++) begin
      access(1'b0, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].be, lat, rd, flt, en_seen, start_a);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d fault", i), 32'(flt), 32'(vecs[i].exp_f));
      check($sformatf("v%0d sram_en seen", i), 32'(en_seen), 32'(!vecs[i].exp_f));
      if (vecs[i].chk_rd) check($sformatf("v%0d read_data", i), rd, vecs[i].exp_rd);
    end
`else
    access(1'b0, 1'b1, 32'h8, 32'h55, 4'hF, lat, rd, flt, en_seen, start_a);
    check("wb write latency", 32'(lat), 32'd0);
    check("wb write fault", 32'(flt), 32'd0);
    access(1'b0, 1'b0, 32'h8, 32'h0, 4'h0, lat, rd, flt, en_seen, start_b);
    check("wb read starts cycle 1", 32'(start_b - start_a), 32'd1);
    check("wb read stalled", 32'((lat > 4) && (lat < 40)), 32'd1);
    check("wb read data", rd, 32'h55);
    check("wb read fault", 32'(flt), 32'd0);
    access(1'b0, 1'b0, 32'h0001_0000, 32'h0, 4'h0, lat, rd, flt, en_seen, start_a);
    check("wb fault latency", 32'(lat), 32'd1);
    check("wb fault flag", 32'(flt), 32'd1);
    check("wb fault data", rd, 32'd0);
    check("wb fault sram_en", 32'(en_seen), 32'd0);
`endif

    access(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd, flt, en_seen, start_a);
    check("ws0 read0 latency", 32'(lat), 32'd3);
    check("ws0 read0 data", rd, 32'hA5000000);
    access(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, lat, rd, flt, en_seen, start_b);
    check("ws0 read1 latency", 32'(lat), 32'd3);
    check("ws0 read1 data", rd, 32'hA5000001);
    check("ws0 read1 ready cycle", 32'(start_b - start_a + lat), 32'd7);

    @(negedge clk);
    sel = 1'b0; we = 1'b0; address = 32'h30; req0 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle0("mid-wait reset");
    req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 1'b0, 32'h30, 32'h0, 4'h0, lat, rd, flt, en_seen, start_a);
    check("post-reset latency", 32'(lat), 32'd4);
    check("post-reset data", rd, 32'h5A00000C);
    check("post-reset fault", 32'(flt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_ram_controller.md
# data_ram_controller

- Sits directly downstream of the CPU's data-memory port, between the core and a single-port synchronous SRAM.
- Decodes and range-checks each request, inserts a configurable number of wait states and returns a one-cycle `ready` pulse with registered read data.
- Optionally posts writes through a one-entry write buffer.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 12: word-address bits driven to the SRAM. Capacity is 2^ADDRESS_WIDTH words.
- `WAIT_STATES`, 1: extra cycles inserted before the response. Legal range 0..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  1  access request; held high by the core until `ready`.
- `we`  in  1  1 = write, 0 = read.
- `address`  in  32  byte address; bits [1:0] are ignored.
- `write_data`  in  32  write word, already lane-aligned by the core.
- `byte_enable`  in  4  write lane mask, passed through unchanged.
- `ready`  out  1  one-cycle completion pulse.
- `read_data`  out  32  read word; valid while `ready`.
- `fault`  out  1  out-of-range access; valid while `ready`.
- `sram_en`  out  1  SRAM access strobe (registered).
- `sram_we`  out  1  SRAM write enable (registered).
- `sram_addr`  out  ADDRESS_WIDTH  word address, equal to address[ADDRESS_WIDTH+1:2].
- `sram_wdata`  out  32  SRAM write data.
- `sram_be`  out  4  SRAM byte enables.
- `sram_rdata`  in  32  SRAM read data; valid one cycle after the `sram_en` cycle.

## Operation
States: IDLE, ISSUE, CAPTURE, WAIT, RESP.
- **IDLE**
  - If `req` is high and address[31:ADDRESS_WIDTH+2] ≠ 0: go to RESP with fault=1 and read_data=0. No SRAM access is made.
  - Otherwise, if `req` is high: latch we, address, write_data and byte_enable, then go to ISSUE.
- **ISSUE**
  - `sram_en`=1 for exactly this cycle.
  - `sram_we`=we.
  - `sram_addr`, `sram_wdata` and `sram_be` are taken from the latched values.
  - Next state is CAPTURE.
- **CAPTURE**
  - For reads, load `read_data` from `sram_rdata` at the end of the cycle. For writes, `read_data` is left unchanged.
  - Load the wait counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES > 0, else go to RESP.
- **WAIT**
  - Decrement the counter each cycle.
  - Go to RESP when the counter reaches 1.
- **RESP**
  - `ready`=1 for this cycle only.
  - Next state is IDLE.
  - `req` seen in this cycle is not sampled. The core advances on `ready`, and a new request is sampled in IDLE on the following cycle.

Other rules:
- `fault` is cleared on every non-fault response.
- `sram_we`, `sram_be` and `sram_wdata` are don't-care while `sram_en`=0, but are driven to 0 outside ISSUE.
- Address wrap: none. Any bit above the SRAM range causes a fault, never an aliased access.

## Timing
- Reset (asynchronous): all outputs are 0, state is IDLE, wait counter is 0, write buffer (if present) is empty.
- Reset asserted mid-access aborts the access immediately. A partial SRAM write (ISSUE already past) is not undone.
- Read or write latency, counted from the req-sampled cycle 0: `ready` in cycle 3+WAIT_STATES. With WAIT_STATES=1 this is cycle 4.
- Fault latency: `ready` in cycle 1.
- Throughput: one access every 4+WAIT_STATES cycles.
- `req` dropping before `ready` is a protocol violation; the access completes regardless.

## Configuration
Macro: `DATA_RAM_CONTROLLER_WRITE_BUFFER_EN`.

When defined:
- An in-range write sampled in IDLE while the buffer is empty is latched into the buffer.
- `ready` is driven combinationally in that same cycle 0.
- The buffer then drains via ISSUE/CAPTURE/WAIT, skipping RESP.
- Any request, read or write, arriving while the buffer is full stalls in IDLE until the drain completes, then proceeds normally.
- Fault detection is unchanged.

When not defined: writes follow the read timing exactly.

## Structure
- Add the state enum `ram_ctrl_state_t` and the constant `RAM_CTRL_MAX_WAIT` = 15 to the shared `cpu_types` package.
- One sub-module, `ram_write_buffer`, holds the buffered address, data and byte_enable plus a full flag. It is instantiated only under the macro.

## Test plan
- WAIT_STATES=1: write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10.
  - Both accesses give `ready` in cycle 4.
  - The read returns 0xDEADBEEF with fault=0.
- Write 0x000000AA to 0x20 with be=4'b0001 over existing 0x11223344, then read 0x20 → 0x112233AA.
- Read from 0x0001_0000 (ADDRESS_WIDTH=12) → `ready` in cycle 1, fault=1, read_data=0, `sram_en` never high.
- WAIT_STATES=0: back-to-back reads of 0x0 and 0x4 → `ready` in cycles 3 and 7.
- Assert `rst_n`=0 during WAIT → all outputs 0 asynchronously, next request starts cleanly from IDLE.
- With the macro defined:
  - write 0x55 to 0x8 → `ready` in cycle 0;
  - a read of 0x8 issued in cycle 1 stalls until the drain finishes, then returns 0x55.
